// File: rtl/seg7_pkg.sv
// Shared definitions for the two-digit multiplexed 7-segment driver.
// Holds the display phase enum, the blank segment code and the
// hex-to-segment encode table (active-low, bit 6 = g ... bit 0 = a).
package seg7_pkg;

    // Which digit the multiplexed display is currently driving.
    typedef enum logic {
        PH_HI = 1'b0,
        PH_LO = 1'b1
    } phase_e;

    // All segments off (active-low).
    localparam logic [6:0] BLANK_CODE = 7'h7F;

    // Encode table, entry 15 first so SEG_TABLE[n] is the code for digit n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E D C
        7'h03, 7'h08, 7'h10, 7'h00,   // B A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    // Table lookup; every 4-bit input maps to a legal code.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational hex digit to active-low 7-segment code.
// Ports:
//   nibble - 4-bit digit value 0..F
//   seg    - 7-bit active-low segment code (bit 6 = g ... bit 0 = a)
module seg7_encode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seg7_driver.sv
// Two-digit multiplexed 7-segment display driver.
// Alternates between the high and low digit every REFRESH_DIV cycles,
// blanking the first BLANK_CYCLES of each phase to avoid ghosting. New
// values are held in a shadow register and committed only on the
// LO->HI phase change so both digits update together.
// Ports:
//   clk     - clock, rising edge
//   rst     - synchronous active-high reset
//   load    - request to display value
//   value   - [7:4] high digit, [3:0] low digit, sampled when load=1
//   segval  - registered active-low segment code
//   segsel  - registered digit select, 1 = high digit
//   blank   - registered, 1 while segval is the blank code
//   pending - a loaded value is waiting for commit
module seg7_driver
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV  = 1024,
    parameter int BLANK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] value,
    output logic [6:0] segval,
    output logic       segsel,
    output logic       blank,
    output logic       pending
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

    phase_e           phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       disp_q, disp_d;
    logic [7:0]       shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic [6:0]       segval_q, segval_d;
    logic             segsel_q, segsel_d;
    logic             blank_q, blank_d;

    logic             cnt_last_s;
    logic             commit_s;
    logic [3:0]       nibble_s;
    logic [6:0]       enc_seg_s;

    seg7_encode u_encode (
        .nibble (nibble_s),
        .seg    (enc_seg_s)
    );

    // Next-state logic for phase, counter, commit path and output codes.
    always_comb begin
        cnt_last_s = (cnt_q == CNT_LAST);
        commit_s   = cnt_last_s && (phase_q == PH_LO);

        if (cnt_last_s) begin
            cnt_d   = {CNT_W{1'b0}};
            phase_d = (phase_q == PH_HI) ? PH_LO : PH_HI;
        end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            phase_d = phase_q;
        end

        shadow_d = load ? value : shadow_q;

        // On the commit edge an incoming load bypasses the shadow.
        if (commit_s) begin
            if (load) begin
                disp_d = value;
            end else if (pending_q) begin
                disp_d = shadow_q;
            end else begin
                disp_d = disp_q;
            end
            pending_d = 1'b0;
        end else begin
            disp_d    = disp_q;
            pending_d = pending_q | load;
        end

        nibble_s = (phase_q == PH_HI) ? disp_q[7:4] : disp_q[3:0];
        segsel_d = (phase_q == PH_HI);
        blank_d  = (cnt_q < BLANK_END);
        segval_d = blank_d ? BLANK_CODE : enc_seg_s;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q   <= PH_HI;
            cnt_q     <= {CNT_W{1'b0}};
            disp_q    <= 8'h00;
            shadow_q  <= 8'h00;
            pending_q <= 1'b0;
            segval_q  <= BLANK_CODE;
            segsel_q  <= 1'b1;
            blank_q   <= 1'b1;
        end else begin
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            disp_q    <= disp_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            segval_q  <= segval_d;
            segsel_q  <= segsel_d;
            blank_q   <= blank_d;
        end
    end

    assign segval  = segval_q;
    assign segsel  = segsel_q;
    assign blank   = blank_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_seg7_driver.sv
// Directed self-checking bench for seg7_driver (REFRESH_DIV=8, BLANK_CYCLES=2).
module tb_seg7_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [7:0] value;
    logic [6:0] segval;
    logic       segsel;
    logic       blank;
    logic       pending;

    int checks   = 0;
    int failures = 0;

    seg7_driver #(
        .REFRESH_DIV  (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .value   (value),
        .segval  (segval),
        .segsel  (segsel),
        .blank   (blank),
        .pending (pending)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Downstream segment-to-hex converter model, written from the code list.
    task automatic seg2hex(input logic [6:0] seg, output logic [3:0] hx, output logic err);
        err = 1'b0;
        case (seg)
            7'h40: hx = 4'h0;  7'h79: hx = 4'h1;  7'h24: hx = 4'h2;  7'h30: hx = 4'h3;
            7'h19: hx = 4'h4;  7'h12: hx = 4'h5;  7'h02: hx = 4'h6;  7'h78: hx = 4'h7;
            7'h00: hx = 4'h8;  7'h10: hx = 4'h9;  7'h08: hx = 4'hA;  7'h03: hx = 4'hB;
            7'h46: hx = 4'hC;  7'h21: hx = 4'hD;  7'h06: hx = 4'hE;  7'h0E: hx = 4'hF;
            default: begin hx = 4'h0; err = 1'b1; end
        endcase
    endtask

    // One full phase; optionally pulses load before the edge at position load_at.
    task automatic run_phase(input logic hi, input logic [6:0] code, input string tag,
                             input int load_at, input logic [7:0] lval);
        for (int k = 0; k < 8; k++) begin
            if (k == load_at) begin
                load  = 1'b1;
                value = lval;
            end
            tick();
            load = 1'b0;
            chk({tag, "_sel"}, 32'(segsel), 32'(hi));
            chk({tag, "_blank"}, 32'(blank), (k < 2) ? 32'd1 : 32'd0);
            chk({tag, "_seg"}, 32'(segval), (k < 2) ? 32'h7F : 32'(code));
        end
    endtask

    logic [7:0] prev_v;
    logic [7:0] new_v;
    logic [3:0] hx;
    logic       er;
    logic [3:0] exp_n;

    initial begin
        rst   = 1'b1;
        load  = 1'b0;
        value = 8'h00;

        // Reset held three cycles.
        tick(); tick(); tick();
        chk("rst_seg", 32'(segval), 32'h7F);
        chk("rst_sel", 32'(segsel), 32'd1);
        chk("rst_blank", 32'(blank), 32'd1);
        chk("rst_pending", 32'(pending), 32'd0);
        rst = 1'b0;
        run_phase(1'b1, 7'h40, "rst_hi", -1, 8'h00);
        run_phase(1'b0, 7'h40, "rst_lo", -1, 8'h00);

        // Load mid-HI: display holds 00 until the LO->HI edge.
        run_phase(1'b1, 7'h40, "a5_hi0", 3, 8'hA5);
        chk("a5_pend1", 32'(pending), 32'd1);
        run_phase(1'b0, 7'h40, "a5_lo0", -1, 8'h00);
        chk("a5_pend0", 32'(pending), 32'd0);
        run_phase(1'b1, 7'h08, "a5_hi", -1, 8'h00);
        run_phase(1'b0, 7'h12, "a5_lo", -1, 8'h00);

        // Back-to-back loads: last one wins.
        run_phase(1'b1, 7'h08, "b2b_hi0", 2, 8'h12);
        chk("b2b_pend1", 32'(pending), 32'd1);
        run_phase(1'b0, 7'h12, "b2b_lo0", 1, 8'h3C);
        chk("b2b_pend0", 32'(pending), 32'd0);
        run_phase(1'b1, 7'h30, "b2b_hi", -1, 8'h00);
        run_phase(1'b0, 7'h46, "b2b_lo", -1, 8'h00);

        // Load on the commit edge itself.
        run_phase(1'b1, 7'h30, "ce_hi0", -1, 8'h00);
        run_phase(1'b0, 7'h46, "ce_lo0", 7, 8'hF0);
        chk("ce_pend", 32'(pending), 32'd0);
        run_phase(1'b1, 7'h0E, "ce_hi", -1, 8'h00);
        run_phase(1'b0, 7'h40, "ce_lo", -1, 8'h00);
        chk("ce_pend_after", 32'(pending), 32'd0);

        // Reset at LO cnt=5 with a value pending; a load during reset is dropped.
        run_phase(1'b1, 7'h0E, "rm_hi0", 5, 8'h77);
        chk("rm_pend1", 32'(pending), 32'd1);
        for (int k = 0; k < 5; k++) tick();
        chk("rm_sel_lo", 32'(segsel), 32'd0);
        rst   = 1'b1;
        load  = 1'b1;
        value = 8'h99;
        tick();
        rst  = 1'b0;
        load = 1'b0;
        chk("rm_seg", 32'(segval), 32'h7F);
        chk("rm_sel", 32'(segsel), 32'd1);
        chk("rm_blank", 32'(blank), 32'd1);
        chk("rm_pending", 32'(pending), 32'd0);
        run_phase(1'b1, 7'h40, "rm_hi", -1, 8'h00);
        run_phase(1'b0, 7'h40, "rm_lo", -1, 8'h00);
        chk("rm_pend_after", 32'(pending), 32'd0);

        // Loopback through the converter for all 16 digit pairs.
        prev_v = 8'h00;
        for (int i = 0; i <= 16; i++) begin
            new_v = {4'(i), 4'(15 - i)};
            for (int k = 0; k < 16; k++) begin
                if (k == 2 && i < 16) begin
                    load  = 1'b1;
                    value = new_v;
                end
                tick();
                load = 1'b0;
                seg2hex(segval, hx, er);
                exp_n = (k < 8) ? prev_v[7:4] : prev_v[3:0];
                chk("loop_err", 32'(er), ((k % 8) < 2) ? 32'd1 : 32'd0);
                if ((k % 8) >= 2) begin
                    if (k < 8) chk("HiSegVal", 32'(hx), 32'(exp_n));
                    else       chk("LoSegVal", 32'(hx), 32'(exp_n));
                end
            end
            prev_v = new_v;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
